// File: rtl/id_decode_stage.sv
// RV64I instruction-decode stage: opcode classification, immediate selection,
// register-field extraction and an ID/EX output slot with a one-entry skid.
module id_decode_stage #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 4,
    localparam int TW          = $clog2(IMM_TYPE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [TW-1:0]         imm_type,
    input  logic [DATA_WIDTH-1:0] imm_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [DATA_WIDTH-1:0] out_imm,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic                  out_use_imm,
    output logic                  out_illegal
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] imm;
        logic                  use_imm;
        logic                  illegal;
    } id_ex_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_GEN  = 2'd1;
    localparam logic [1:0] SEL_JAL  = 2'd2;

    logic [6:0]            w_opcode;
    logic [1:0]            w_sel;
    logic                  w_use_imm;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_jal_imm;
    logic [DATA_WIDTH-1:0] w_imm;
    logic                  w_accept;
    id_ex_t                w_new;

    id_ex_t r_main;
    id_ex_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;

    assign w_opcode = in_inst[6:0];

    always_comb begin
        imm_type  = TW'(0);
        w_sel     = SEL_ZERO;
        w_use_imm = 1'b0;
        w_illegal = 1'b0;
        unique case (w_opcode)
            OPC_LOAD, OPC_OPIMM, OPC_OPIMMW, OPC_JALR, OPC_SYSTEM: begin
                imm_type  = TW'(0);
                w_sel     = SEL_GEN;
                w_use_imm = 1'b1;
            end
            OPC_STORE: begin
                imm_type  = TW'(1);
                w_sel     = SEL_GEN;
                w_use_imm = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type  = TW'(2);
                w_sel     = SEL_GEN;
                w_use_imm = 1'b1;
            end
            OPC_BRANCH: begin
                imm_type = TW'(3);
                w_sel    = SEL_GEN;
            end
            OPC_JAL: begin
                w_sel     = SEL_JAL;
                w_use_imm = 1'b1;
            end
            OPC_OP, OPC_OPW: begin
                w_sel = SEL_ZERO;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // J-type immediates never go through the shared generator
    assign w_jal_imm = {{(DATA_WIDTH-21){in_inst[31]}}, in_inst[31],
                        in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    always_comb begin
        w_imm = '0;
        unique case (w_sel)
            SEL_GEN: w_imm = imm_in;
            SEL_JAL: w_imm = w_jal_imm;
            default: w_imm = '0;
        endcase
    end

    assign w_new.pc      = in_pc;
    assign w_new.inst    = in_inst;
    assign w_new.imm     = w_imm;
    assign w_new.use_imm = w_use_imm;
    assign w_new.illegal = w_illegal;

    assign in_ready = !r_skid_valid;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || out_ready) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= w_new;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= w_new;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_main_valid;
    assign out_pc      = r_main.pc;
    assign out_inst    = r_main.inst;
    assign out_imm     = r_main.imm;
    assign out_use_imm = r_main.use_imm;
    assign out_illegal = r_main.illegal;
    assign out_rs1     = r_main.inst[19:15];
    assign out_rs2     = r_main.inst[24:20];
    assign out_rd      = r_main.inst[11:7];

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: acts as the immediate generator and checks the
// ID/EX stream against a scoreboard of expected bundles.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic [1:0]  imm_type;
    logic [63:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_use_imm;
    logic        out_illegal;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] imm;
        logic        use_imm;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [63:0] e_imm;
    logic        e_use;
    logic        e_ill;
    bit          hold;
    logic [63:0] h_pc;
    logic [31:0] h_inst;
    logic [63:0] h_imm;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .imm_type    (imm_type),
        .imm_in      (imm_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_imm     (out_imm),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_use_imm (out_use_imm),
        .out_illegal (out_illegal)
    );

    // Immediate generator model
    always_comb begin
        case (imm_type)
            2'd0:    imm_in = {{52{in_inst[31]}}, in_inst[31:20]};
            2'd1:    imm_in = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            2'd2:    imm_in = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
            default: imm_in = {{51{in_inst[31]}}, in_inst[31], in_inst[7],
                               in_inst[30:25], in_inst[11:8], 1'b0};
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_pc", out_pc, h_pc);
                chk("hold_inst", {32'b0, out_inst}, {32'b0, h_inst});
                chk("hold_imm", out_imm, h_imm);
            end
            hold   = out_valid && !out_ready && !flush;
            h_pc   = out_pc;
            h_inst = out_inst;
            h_imm  = out_imm;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", out_pc, 64'hDEAD);
                end else begin
                    e = q.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_inst", {32'b0, out_inst}, {32'b0, e.inst});
                    chk("sb_imm", out_imm, e.imm);
                    chk("sb_use", {63'b0, out_use_imm}, {63'b0, e.use_imm});
                    chk("sb_ill", {63'b0, out_illegal}, {63'b0, e.ill});
                    chk("sb_rs1", {59'b0, out_rs1}, {59'b0, e.inst[19:15]});
                    chk("sb_rs2", {59'b0, out_rs2}, {59'b0, e.inst[24:20]});
                    chk("sb_rd", {59'b0, out_rd}, {59'b0, e.inst[11:7]});
                end
            end
            if (flush)
                q.delete();
            else if (in_valid && in_ready)
                q.push_back('{in_pc, in_inst, e_imm, e_use, e_ill});
        end
    end

    task automatic send(input logic [63:0] pc, input logic [31:0] inst,
                        input logic [1:0] et, input logic [63:0] ei,
                        input logic eu, input logic el);
        bit acc;
        acc      = 1'b0;
        in_pc    = pc;
        in_inst  = inst;
        e_imm    = ei;
        e_use    = eu;
        e_ill    = el;
        in_valid = 1'b1;
        #1;
        chk("imm_type", {62'b0, imm_type}, {62'b0, et});
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready && !rst && !flush;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        e_imm     = '0;
        e_use     = 1'b0;
        e_ill     = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        out_ready = 1'b1;
        send(64'h100, 32'hFFF00093, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        chk("lat_valid", {63'b0, out_valid}, 64'd1);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rd", {59'b0, out_rd}, 64'd1);
        chk("addi_rs1", {59'b0, out_rs1}, 64'd0);
        chk("addi_use", {63'b0, out_use_imm}, 64'd1);
        send(64'h104, 32'h0020B423, 2'd1, 64'd8, 1'b1, 1'b0);
        chk("sd_rs1", {59'b0, out_rs1}, 64'd1);
        chk("sd_rs2", {59'b0, out_rs2}, 64'd2);
        send(64'h108, 32'hFE000EE3, 2'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
        send(64'h10C, 32'h001000EF, 2'd0, 64'h800, 1'b1, 1'b0);
        chk("jal_rd", {59'b0, out_rd}, 64'd1);
        chk("jal_imm", out_imm, 64'h800);
        send(64'h110, 32'h0000007F, 2'd0, 64'd0, 1'b0, 1'b1);
        chk("ill_flag", {63'b0, out_illegal}, 64'd1);
        send(64'h114, 32'h002081B3, 2'd0, 64'd0, 1'b0, 1'b0);
        send(64'h118, 32'h12345037, 2'd2, 64'h1234_5000, 1'b1, 1'b0);
        idle(2);
        chk("dir_drain", q.size(), 64'd0);

        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send(64'(i * 4), {12'(i + 1), 5'd1, 3'd0, 5'd2, 7'h13},
                         2'd0, 64'(i + 1), 1'b1, 1'b0);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
                chk("bp_valid", {63'b0, out_valid}, 64'd1);
                chk("bp_main_pc", out_pc, 64'h0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("bp_drain", q.size(), 64'd0);

        out_ready = 1'b0;
        send(64'h200, 32'h00100093, 2'd0, 64'd1, 1'b1, 1'b0);
        send(64'h204, 32'h00200093, 2'd0, 64'd2, 1'b1, 1'b0);
        in_pc    = 64'h208;
        in_inst  = 32'h00300093;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send(64'h300, 32'h00400093, 2'd0, 64'd4, 1'b1, 1'b0);
        idle(3);
        chk("flush_drain", q.size(), 64'd0);

        out_ready = 1'b0;
        send(64'h400, 32'h00500093, 2'd0, 64'd5, 1'b1, 1'b0);
        send(64'h404, 32'h00600093, 2'd0, 64'd6, 1'b1, 1'b0);
        in_pc    = 64'h408;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        send(64'h500, 32'h00700093, 2'd0, 64'd7, 1'b1, 1'b0);
        idle(3);
        chk("rst_drain", q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Instruction-decode stage between the IF/ID register and the execute stage.
- Classifies each incoming RV64I instruction by opcode and drives `imm_type` to the immediate generator, which is instantiated alongside it.
- Accepts that generator's sign-extended result, computes J-type immediates internally, and extracts register fields.
- Registers the decoded bundle into an ID/EX output slot backed by a one-entry skid buffer, with valid/ready handshakes on both sides and a flush input.

Parameters:
- DATA_WIDTH, 64, datapath and immediate width.
- INST_WIDTH, 32, instruction width.
- IMM_TYPE_NUM, 4, number of immediate encodings the generator supports; imm_type width is $clog2(IMM_TYPE_NUM).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  pipeline flush from branch resolution.
- in_valid  input  1  IF/ID beat valid.
- in_ready  output  1  stage can accept a beat.
- in_inst  input  INST_WIDTH  instruction word.
- in_pc  input  DATA_WIDTH  instruction PC.
- imm_type  output  $clog2(IMM_TYPE_NUM)  combinational type from in_inst: 00=I, 01=S, 10=U, 11=B.
- imm_in  input  DATA_WIDTH  immediate returned combinationally by the generator for in_inst.
- out_valid  output  1  ID/EX bundle valid.
- out_ready  input  1  execute stage accepts the bundle.
- out_pc  output  DATA_WIDTH  registered PC.
- out_inst  output  INST_WIDTH  registered instruction.
- out_imm  output  DATA_WIDTH  selected immediate.
- out_rs1, out_rs2, out_rd  output  5 each  inst[19:15], inst[24:20], inst[11:7].
- out_use_imm  output  1  ALU operand B is the immediate.
- out_illegal  output  1  opcode not in the decode map.

Behaviour:
- Opcode map (inst[6:0]) -> imm_type / use_imm:
  - LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111, SYSTEM 1110011 -> I / 1.
  - STORE 0100011 -> S / 1.
  - LUI 0110111, AUIPC 0010111 -> U / 1.
  - BRANCH 1100011 -> B / 0.
  - JAL 1101111 -> imm_type driven 00 (don't-care); out_imm = sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} to DATA_WIDTH; use_imm 1.
  - OP 0110011, OP-32 0111011 -> imm_type 00, use_imm 0, out_imm 0.
  - Any other opcode -> illegal=1, use_imm 0, out_imm 0; the beat still flows down the pipe.
- imm_type is purely combinational from in_inst, independent of in_valid.
- Latency: 1 cycle from an accepted input beat to out_valid, when the main slot is free or draining.
- Storage: main slot (drives outputs) plus one skid entry holding a full decoded bundle.
- in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
- Accept = in_valid && in_ready.
- Per cycle, in priority order:
  1. rst or flush: main_valid=0, skid_valid=0, any beat presented that cycle is dropped. Payload registers are not reset; their values are don't-care while invalid.
  2. main empty, or out_ready=1:
     - if skid_valid: skid moves to main, skid_valid=0. No accept is possible this cycle because in_ready=0.
     - else if accept: new beat loads main.
     - else: main_valid=0.
  3. main full, out_ready=0, and accept: beat loads skid, skid_valid=1 (in_ready drops next cycle).
  4. Otherwise: hold all state.
- Handshake rules:
  - out_valid=1 with out_ready=0 holds every out_* field stable until the transfer.
  - No beat is lost or duplicated.
  - Order is strictly preserved.
- Simultaneous flush with out_ready=1: the bundle in main counts as consumed by the execute stage, then all state clears.
- Reset values: out_valid=0; in_ready=1 from the first cycle after rst deasserts; in_ready is don't-care while rst is high.
- Sustained throughput is 1 beat/cycle while out_ready stays high.

Test Plan:
- Addi with execute stage ready: inst 0xFFF00093, in_valid=1, out_ready=1 -> imm_type=00 same cycle; next cycle out_valid=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_rd=1, out_rs1=0, out_use_imm=1.
- Store: inst 0x0020B423 (sd x2,8(x1)) -> imm_type=01, out_imm=8, out_rs1=1, out_rs2=2, use_imm=1.
- Branch and jump:
  - beq 0xFE000EE3 -> imm_type=11, out_imm=0xFFFF_FFFF_FFFF_FFFC, use_imm=0.
  - jal 0x001000EF -> out_imm=0x800, out_rd=1.
- Backpressure: stream PCs 0x0,0x4,0x8,0xC back-to-back; hold out_ready=0 for 3 cycles after the first beat -> main holds 0x0, skid takes 0x4, in_ready=0 while skid is full. Release out_ready -> outputs 0x0,0x4,0x8,0xC in order, with no gaps beyond one cycle per skid drain.
- Flush with skid full, in_valid=1, out_ready=0 -> next cycle out_valid=0, in_ready=1; the flushed beat never appears.
- Illegal opcode and reset:
  - inst 0x0000007F -> out_illegal=1, out_imm=0.
  - Assert rst mid-stream for 1 cycle -> out_valid=0 next cycle; the pipeline resumes cleanly on the next accepted beat.
